// File: rtl/fft_bitrev_buf.sv
// Ping-pong reorder buffer: bit-reversed FFT frames in, natural-order frames out.
// Define FFT_REORDER_CONJ_EN to emit the saturated conjugate on out_img.
module fft_bitrev_buf #(
    parameter int unsigned N_PTS = 256,
    parameter int unsigned DW    = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_real,
    input  logic [DW-1:0] in_img,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_real,
    output logic [DW-1:0] out_img,
    output logic          out_last
);

    localparam int unsigned LOG2N = $clog2(N_PTS);
    localparam int unsigned SW    = 2 * DW;
    localparam logic [LOG2N-1:0] LAST_IDX = LOG2N'(N_PTS - 1);

    // Sample storage; contents after reset are never visible thanks to output gating.
    logic [SW-1:0] mem [2][N_PTS];

    logic [1:0]       full, full_nxt;
    logic             wb, wb_nxt;
    logic             rb, rb_nxt;
    logic [LOG2N-1:0] wcnt, wcnt_nxt;
    logic [LOG2N-1:0] rcnt, rcnt_nxt;

    logic             wr_en;
    logic             rd_en;
    logic [SW-1:0]    rd_word;
    logic [DW-1:0]    rd_real;
    logic [DW-1:0]    rd_img;
    logic [DW-1:0]    img_sel;

    function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] a);
        logic [LOG2N-1:0] r;
        r = '0;
        for (int unsigned i = 0; i < LOG2N; i++) begin
            r[i] = a[LOG2N-1-i];
        end
        return r;
    endfunction

    assign wr_en = in_valid && in_ready;
    assign rd_en = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wb][wcnt] <= {in_real, in_img};
        end
    end

    // Frame bookkeeping; a set on one bank and a clear on the other may coincide.
    always_comb begin
        full_nxt = full;
        wb_nxt   = wb;
        rb_nxt   = rb;
        wcnt_nxt = wcnt;
        rcnt_nxt = rcnt;
        if (wr_en) begin
            wcnt_nxt = wcnt + LOG2N'(1);
            if (wcnt == LAST_IDX) begin
                full_nxt[wb] = 1'b1;
                wb_nxt       = ~wb;
            end
        end
        if (rd_en) begin
            rcnt_nxt = rcnt + LOG2N'(1);
            if (rcnt == LAST_IDX) begin
                full_nxt[rb] = 1'b0;
                rb_nxt       = ~rb;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            full <= '0;
            wb   <= 1'b0;
            rb   <= 1'b0;
            wcnt <= '0;
            rcnt <= '0;
        end else begin
            full <= full_nxt;
            wb   <= wb_nxt;
            rb   <= rb_nxt;
            wcnt <= wcnt_nxt;
            rcnt <= rcnt_nxt;
        end
    end

    assign rd_word = mem[rb][bitrev(rcnt)];
    assign rd_real = rd_word[SW-1:DW];
    assign rd_img  = rd_word[DW-1:0];

`ifdef FFT_REORDER_CONJ_EN
    localparam logic [DW-1:0] SMIN = {1'b1, {(DW-1){1'b0}}};
    // Negating the most negative value saturates to the most positive one.
    assign img_sel = (rd_img == SMIN) ? ~SMIN : (~rd_img + DW'(1));
`else
    assign img_sel = rd_img;
`endif

    // Handshake flags decode registered state; data is zero whenever nothing is offered.
    always_comb begin
        in_ready  = ~full[wb];
        out_valid = full[rb];
        out_real  = '0;
        out_img   = '0;
        out_last  = 1'b0;
        if (full[rb]) begin
            out_real = rd_real;
            out_img  = img_sel;
            out_last = (rcnt == LAST_IDX);
        end
    end

endmodule

// File: tb/tb_fft_bitrev_buf.sv
// Self-checking bench for fft_bitrev_buf (N_PTS=256, DW=16) against a frame-queue model.
module tb_fft_bitrev_buf;

    localparam int N     = 256;
    localparam int LOG2N = 8;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_real;
    logic [15:0] in_img;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_real;
    logic [15:0] out_img;
    logic        out_last;

    int vec  = 0;
    int errs = 0;

    // Model: completed frames in arrival order, the frame being filled, read position in head frame.
    logic [31:0] fq[$];
    logic [31:0] part[$];
    int          k;

    logic        exp_rdy, exp_v, exp_last;
    logic [15:0] exp_r, exp_i;

    fft_bitrev_buf #(.N_PTS(N), .DW(16)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_real(in_real), .in_img(in_img),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_real(out_real), .out_img(out_img), .out_last(out_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int bitrev(input int a);
        int r = 0;
        int v = a;
        for (int i = 0; i < LOG2N; i++) begin
            r = r * 2 + v % 2;
            v = v / 2;
        end
        return r;
    endfunction

    function automatic logic [15:0] conj_img(input logic [15:0] x);
`ifdef FFT_REORDER_CONJ_EN
        if (x == 16'h8000) return 16'h7fff;
        return 16'(-x);
`else
        return x;
`endif
    endfunction

    function automatic void model_expect();
        logic [31:0] e;
        exp_rdy  = (fq.size() < 2 * N);
        exp_v    = (fq.size() > 0);
        exp_r    = '0;
        exp_i    = '0;
        exp_last = 1'b0;
        if (exp_v) begin
            e        = fq[bitrev(k)];
            exp_r    = e[31:16];
            exp_i    = conj_img(e[15:0]);
            exp_last = (k == N - 1);
        end
    endfunction

    task automatic model_reset();
        fq.delete();
        part.delete();
        k = 0;
    endtask

    // Advance one clock, updating the model with the handshakes of the cycle just ending.
    task automatic step();
        bit acc_in  = in_valid && (fq.size() < 2 * N);
        bit acc_out = (fq.size() > 0) && out_ready;
        if (acc_out) begin
            k++;
            if (k == N) begin
                for (int i = 0; i < N; i++) void'(fq.pop_front());
                k = 0;
            end
        end
        if (acc_in) begin
            part.push_back({in_real, in_img});
            if (part.size() == N) begin
                foreach (part[i]) fq.push_back(part[i]);
                part.delete();
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_real = '0; in_img = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        model_reset();
        vec++; if (in_ready !== 1'b1) begin errs++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
        vec++; if (out_valid !== 1'b0) begin errs++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
        vec++; if (out_real !== 16'h0) begin errs++; $display("FAIL reset_out_real got %h exp 0000", out_real); end
        vec++; if (out_img !== 16'h0) begin errs++; $display("FAIL reset_out_img got %h exp 0000", out_img); end
        vec++; if (out_last !== 1'b0) begin errs++; $display("FAIL reset_out_last got %b exp 0", out_last); end
    endtask

    task automatic test_ramp();
        int first_v = -1;
        out_ready = 1'b1;
        for (int c = 0; c < 2 * N + 4; c++) begin
            in_valid = (c < N);
            in_real  = 16'(c);
            in_img   = 16'(-c);
            model_expect();
            if (out_valid === 1'b1 && first_v < 0) first_v = c;
            vec++;
            if ({in_ready, out_valid, out_last, out_real, out_img} !== {exp_rdy, exp_v, exp_last, exp_r, exp_i}) begin
                errs++;
                $display("FAIL ramp cyc=%0d got rdy=%b v=%b last=%b re=%h im=%h exp rdy=%b v=%b last=%b re=%h im=%h",
                         c, in_ready, out_valid, out_last, out_real, out_img, exp_rdy, exp_v, exp_last, exp_r, exp_i);
            end
            if (c >= N && c < 2 * N) begin
                vec++;
                if (out_real !== 16'(bitrev(c - N))) begin
                    errs++;
                    $display("FAIL ramp_order beat=%0d got %0d exp %0d", c - N, out_real, bitrev(c - N));
                end
            end
            step();
        end
        vec++;
        if (first_v != N) begin errs++; $display("FAIL ramp_latency first valid cycle %0d exp %0d", first_v, N); end
    endtask

    task automatic test_back_to_back();
        int beats = 0;
        out_ready = 1'b1;
        for (int c = 0; c < 4 * N + 4; c++) begin
            in_valid = (c < 3 * N);
            in_real  = 16'($urandom);
            in_img   = 16'($urandom);
            model_expect();
            vec++;
            if ({in_ready, out_valid, out_last, out_real, out_img} !== {exp_rdy, exp_v, exp_last, exp_r, exp_i}) begin
                errs++;
                $display("FAIL b2b cyc=%0d got rdy=%b v=%b last=%b re=%h im=%h exp rdy=%b v=%b last=%b re=%h im=%h",
                         c, in_ready, out_valid, out_last, out_real, out_img, exp_rdy, exp_v, exp_last, exp_r, exp_i);
            end
            if (c < 3 * N) begin
                vec++;
                if (in_ready !== 1'b1) begin errs++; $display("FAIL b2b_ready_drop cyc=%0d got %b exp 1", c, in_ready); end
            end
            if (c >= N && c < 4 * N) begin
                vec++;
                if (out_valid !== 1'b1) begin errs++; $display("FAIL b2b_gap cyc=%0d got %b exp 1", c, out_valid); end
            end
            if (out_valid === 1'b1) beats++;
            step();
        end
        vec++;
        if (beats != 3 * N) begin errs++; $display("FAIL b2b_count got %0d exp %0d", beats, 3 * N); end
    endtask

    task automatic test_backpressure();
        int          acc   = 0;
        int          beats = 0;
        int          c     = 0;
        logic [31:0] cur   = $urandom;
        out_ready = 1'b0;
        for (c = 0; c < 2 * N + 20; c++) begin
            in_valid = 1'b1;
            {in_real, in_img} = cur;
            model_expect();
            vec++;
            if ({in_ready, out_valid, out_last, out_real, out_img} !== {exp_rdy, exp_v, exp_last, exp_r, exp_i}) begin
                errs++;
                $display("FAIL bp_hold cyc=%0d got rdy=%b v=%b last=%b re=%h im=%h exp rdy=%b v=%b last=%b re=%h im=%h",
                         c, in_ready, out_valid, out_last, out_real, out_img, exp_rdy, exp_v, exp_last, exp_r, exp_i);
            end
            if (acc == 2 * N) begin
                vec++;
                if (in_ready !== 1'b0) begin errs++; $display("FAIL bp_full cyc=%0d got %b exp 0", c, in_ready); end
            end
            if (exp_rdy) begin acc++; cur = $urandom; end
            step();
        end
        out_ready = 1'b1;
        for (c = 0; c < 3000 && (acc < 3 * N || fq.size() > 0); c++) begin
            in_valid = (acc < 3 * N);
            {in_real, in_img} = cur;
            model_expect();
            vec++;
            if ({in_ready, out_valid, out_last, out_real, out_img} !== {exp_rdy, exp_v, exp_last, exp_r, exp_i}) begin
                errs++;
                $display("FAIL bp_drain cyc=%0d got rdy=%b v=%b last=%b re=%h im=%h exp rdy=%b v=%b last=%b re=%h im=%h",
                         c, in_ready, out_valid, out_last, out_real, out_img, exp_rdy, exp_v, exp_last, exp_r, exp_i);
            end
            if (beats == N) begin
                vec++;
                if (in_ready !== 1'b1) begin errs++; $display("FAIL bp_release got %b exp 1", in_ready); end
            end
            if (exp_v) beats++;
            if (in_valid && exp_rdy) begin acc++; cur = $urandom; end
            step();
        end
        in_valid = 1'b0;
        vec++;
        if (fq.size() != 0 || acc != 3 * N) begin
            errs++;
            $display("FAIL bp_timeout frames_left=%0d accepted=%0d exp 0 and %0d", fq.size() / N, acc, 3 * N);
        end
    endtask

    task automatic test_conj();
        logic [31:0] d[N];
        for (int n = 0; n < N; n++) d[n] = $urandom;
        d[0][15:0]   = 16'h8000;
        d[128][15:0] = 16'h0005;
        out_ready = 1'b1;
        for (int c = 0; c < 2 * N + 2; c++) begin
            in_valid = (c < N);
            {in_real, in_img} = (c < N) ? d[c] : 32'h0;
            model_expect();
            vec++;
            if ({in_ready, out_valid, out_last, out_real, out_img} !== {exp_rdy, exp_v, exp_last, exp_r, exp_i}) begin
                errs++;
                $display("FAIL conj cyc=%0d got rdy=%b v=%b last=%b re=%h im=%h exp rdy=%b v=%b last=%b re=%h im=%h",
                         c, in_ready, out_valid, out_last, out_real, out_img, exp_rdy, exp_v, exp_last, exp_r, exp_i);
            end
            if (c == N) begin
                vec++;
`ifdef FFT_REORDER_CONJ_EN
                if (out_img !== 16'h7fff) begin errs++; $display("FAIL conj_sat got %h exp 7fff", out_img); end
`else
                if (out_img !== 16'h8000) begin errs++; $display("FAIL conj_pass got %h exp 8000", out_img); end
`endif
                vec++;
                if (out_real !== d[0][31:16]) begin errs++; $display("FAIL conj_real got %h exp %h", out_real, d[0][31:16]); end
            end
            if (c == N + 1) begin
                vec++;
`ifdef FFT_REORDER_CONJ_EN
                if (out_img !== 16'hfffb) begin errs++; $display("FAIL conj_neg got %h exp fffb", out_img); end
`else
                if (out_img !== 16'h0005) begin errs++; $display("FAIL conj_five got %h exp 0005", out_img); end
`endif
            end
            step();
        end
    endtask

    task automatic test_reset_mid();
        int beats = 0;
        out_ready = 1'b1;
        for (int c = 0; c < 100; c++) begin
            in_valid = 1'b1;
            in_real  = 16'($urandom);
            in_img   = 16'($urandom);
            step();
        end
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        model_reset();
        vec++;
        if ({in_ready, out_valid, out_last, out_real, out_img} !== {1'b1, 1'b0, 1'b0, 32'h0}) begin
            errs++;
            $display("FAIL mid_reset got rdy=%b v=%b last=%b re=%h im=%h exp 1 0 0 0000 0000",
                     in_ready, out_valid, out_last, out_real, out_img);
        end
        @(posedge clk);
        #1 rst = 1'b0;
        for (int c = 0; c < 2 * N + 4; c++) begin
            in_valid = (c < N);
            in_real  = 16'($urandom);
            in_img   = 16'($urandom);
            model_expect();
            vec++;
            if ({in_ready, out_valid, out_last, out_real, out_img} !== {exp_rdy, exp_v, exp_last, exp_r, exp_i}) begin
                errs++;
                $display("FAIL mid cyc=%0d got rdy=%b v=%b last=%b re=%h im=%h exp rdy=%b v=%b last=%b re=%h im=%h",
                         c, in_ready, out_valid, out_last, out_real, out_img, exp_rdy, exp_v, exp_last, exp_r, exp_i);
            end
            if (out_valid === 1'b1) beats++;
            step();
        end
        vec++;
        if (beats != N) begin errs++; $display("FAIL mid_count got %0d exp %0d", beats, N); end
    endtask

    task automatic test_random();
        logic [31:0] cur = $urandom;
        int          c;
        for (c = 0; c < 6000; c++) begin
            in_valid  = (c < 5000) && ($urandom_range(0, 9) < 7);
            out_ready = ($urandom_range(0, 9) < 6) || (c >= 5000);
            {in_real, in_img} = cur;
            model_expect();
            vec++;
            if ({in_ready, out_valid, out_last, out_real, out_img} !== {exp_rdy, exp_v, exp_last, exp_r, exp_i}) begin
                errs++;
                $display("FAIL random cyc=%0d got rdy=%b v=%b last=%b re=%h im=%h exp rdy=%b v=%b last=%b re=%h im=%h",
                         c, in_ready, out_valid, out_last, out_real, out_img, exp_rdy, exp_v, exp_last, exp_r, exp_i);
            end
            if (in_valid && exp_rdy) cur = $urandom;
            step();
        end
        vec++;
        if (fq.size() != 0) begin errs++; $display("FAIL random_drain frames_left=%0d exp 0", fq.size() / N); end
    endtask

    initial begin
        k = 0;
        test_reset();
        test_ramp();
        test_back_to_back();
        test_backpressure();
        test_reset();
        test_conj();
        test_reset_mid();
        test_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

endmodule

// File: doc/fft_bitrev_buf.md
# fft_bitrev_buf

Parametrised ping-pong reorder buffer that sits on the output of the radix-2 FFT core and converts each frame from bit-reversed to natural order. The 256-point, no-backpressure path is generalised to any power-of-two point count and sample width, with valid/ready flow control on both sides. Output is delivered zero-gated so the bench reset checks hold unchanged. An optional conjugate stage supports the IFFT-by-conjugation mode.

## Interface
- N_PTS, 256, points per frame; power of two, 4..4096; LOG2N = log2(N_PTS) is derived internally.
- DW, 16, bits per real/imag component; signed Q1.(DW-1).
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset. One clock domain only.
- in_valid  input  1  input sample present.
- in_ready  output  1  buffer can accept a sample.
- in_real  input  DW  signed real part, bit-reversed order.
- in_img  input  DW  signed imaginary part.
- out_valid  output  1  output sample present.
- out_ready  input  1  downstream accepts the sample.
- out_real  output  DW  signed real part, natural order.
- out_img  output  DW  signed imaginary part, natural order.
- out_last  output  1  marks the final sample (index N_PTS-1) of a frame.

## Operation
- Storage: two banks of N_PTS x 2·DW flops.
- Control state:
  - full[1:0]: per-bank frame-complete flags.
  - wb, rb: write and read bank selects.
  - wcnt, rcnt: LOG2N-bit counters.
- Write side:
  - in_ready = !full[wb].
  - On in_valid && in_ready: mem[wb][wcnt] <= {in_real, in_img}, then wcnt++.
  - On accept with wcnt == N_PTS-1: set full[wb], toggle wb, wrap wcnt to 0.
- Read side:
  - out_valid = full[rb].
  - Data = mem[rb][bitrev(rcnt)], where bitrev reverses the LOG2N bits.
  - On out_valid && out_ready: rcnt++.
  - When that accepted beat has rcnt == N_PTS-1: clear full[rb], toggle rb, wrap rcnt.
- out_last = out_valid && rcnt == N_PTS-1.
- out_real, out_img, out_last are 0 whenever out_valid = 0. No X on the outputs.
- Simultaneous set and clear of full on different banks in the same cycle: both take effect.
- A bank freed at edge E is writable from the cycle after E (in_ready is decoded from registered full).
- in_valid while in_ready = 0: the sample is not taken. The source holds it.
- Reset: full = 0, wb = rb = 0, wcnt = rcnt = 0.
  - Outputs after reset: in_ready = 1, out_valid = 0, out_real = out_img = 0, out_last = 0.
  - Memory is not cleared; output gating makes its contents invisible.
- Reset mid-frame: partial and complete frames are discarded. The next accepted sample is index 0 of a new frame.

## Timing
- Latency: the Nth sample is accepted at edge E; out_valid = 1 in the cycle after E, showing natural index 0.
- Throughput: 1 sample/cycle each side. With in_valid and out_ready held high, frames stream with no in_ready drop.
- Output read is combinational from registered state: no output register, no read bubble.
- Backpressure: with out_ready = 0, out_* hold stable. At most 2 complete frames are buffered.

## Configuration
- FFT_REORDER_CONJ_EN defined:
  - out_img = saturate(-mem_img). The value -2^(DW-1) maps to 2^(DW-1)-1.
  - out_real is unchanged.
  - Zero gating still applies.
- FFT_REORDER_CONJ_EN undefined: out_img = mem_img, passed through.

## Test plan
- Reset: hold rst high 2 cycles, release -> in_ready = 1, out_valid = 0, out_real = out_img = 0, out_last = 0; no X.
- N_PTS = 256, DW = 16, out_ready = 1, feed real = n, img = -n for n = 0..255 -> out_valid rises the cycle after the 256th accept; out_real sequence 0, 128, 64, 192, 32, ... (bitrev8(k)); out_img = -out_real; out_last only on the 256th beat. Repeat with N_PTS = 16: sequence 0, 8, 4, 12, 2, ...
- 3 frames back-to-back, in_valid and out_ready held 1 -> in_ready never drops; 768 outputs, each frame correctly reordered; no gap between frames on out_valid.
- out_ready = 0, stream 513 samples -> in_ready = 0 after the 512th accept and the 513th sample is held; out_* stable. Then raise out_ready -> in_ready returns 1 the cycle after the 256th output is accepted, and the 513th sample is taken as index 0 of bank 0.
- FFT_REORDER_CONJ_EN defined: input img -32768 -> out_img 32767; img 5 -> -5; real unchanged. Macro undefined: img -32768 -> out_img -32768.
- Feed 100 samples, pulse rst mid-stream, then feed a full 256-sample frame -> exactly 256 outputs, all from the new frame; out_valid stays 0 until that frame completes.
